// File: rtl/ahb_gpio_param.sv
// ahb_gpio_param: parametrised AHB-Lite GPIO slave with per-bit direction,
// input synchroniser, pin parity generation/checking with a sticky error flag,
// and an optional per-bit rising-edge interrupt (enabled by macro GPIO_IRQ_EN).
module ahb_gpio_param #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    input  logic [DATA_W:0]   GPIOIN,
    output logic [DATA_W:0]   GPIOOUT,
    input  logic              PARITYSEL,
    output logic              PARITYERR,
    output logic              GPIOIRQ
);

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_MASK = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;
    localparam logic [2:0] REG_PERR = 3'd4;

    // Reduction parity over the full pin width (data plus parity bit).
    function automatic logic parity_f(input logic [DATA_W:0] v);
        return ^v;
    endfunction

    // Zero-extend a GPIO-width value onto the 32-bit read bus.
    function automatic logic [31:0] zext_f(input logic [DATA_W-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[DATA_W-1:0] = v;
        return r;
    endfunction

    logic [DATA_W:0]   sync_q [SYNC_STAGES];
    logic [DATA_W:0]   sync_in_s;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] dir_q, dir_d;
    logic              perr_sticky_q, perr_sticky_d;
    logic              parityerr_q;
    logic              dp_valid_q;
    logic              dp_write_q;
    logic [2:0]        dp_addr_q;
    logic              accept_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] gpio_data_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    assign HREADYOUT = 1'b1;
    assign accept_s  = HSEL & HREADY & HTRANS[1];
    assign wr_en_s   = dp_valid_q & dp_write_q & HREADY;
    assign wr_data_s = HWDATA[DATA_W-1:0];
    assign sync_in_s = sync_q[SYNC_STAGES-1];
    assign unused_s  = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    // Pin drive: only output-direction bits drive, MSB carries generated parity.
    assign gpio_data_s = out_q & dir_q;
    assign GPIOOUT     = {parity_f({1'b0, gpio_data_s}) ^ PARITYSEL, gpio_data_s};
    assign PARITYERR   = parityerr_q;

    // Input synchroniser chain across all pin bits including parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Address-phase capture into the data-phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 3'd0;
        end else if (HREADY) begin
            dp_valid_q <= accept_s;
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR[4:2];
        end else begin
            dp_valid_q <= dp_valid_q;
            dp_write_q <= dp_write_q;
            dp_addr_q  <= dp_addr_q;
        end
    end

    // Next-state for the data, direction and sticky parity-error registers.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_en_s) begin
            case (dp_addr_q)
                REG_DATA: out_d = wr_data_s;
                REG_DIR:  dir_d = wr_data_s;
                default:  out_d = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
        // A live parity error outranks a simultaneous clear.
        perr_sticky_d = parityerr_q |
                        (perr_sticky_q & ~(wr_en_s & (dp_addr_q == REG_PERR) & HWDATA[0]));
    end

    // State registers for data, direction, parity check and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= '0;
            dir_q         <= '0;
            perr_sticky_q <= 1'b0;
            parityerr_q   <= 1'b0;
        end else begin
            out_q         <= out_d;
            dir_q         <= dir_d;
            perr_sticky_q <= perr_sticky_d;
            parityerr_q   <= parity_f(sync_in_s) != PARITYSEL;
        end
    end

`ifdef GPIO_IRQ_EN
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] edge_q;
    logic              irq_q;

    // Mask write and W1C status update; a new edge wins over its clear.
    always_comb begin
        mask_d   = mask_q;
        status_d = status_q;
        if (wr_en_s && (dp_addr_q == REG_MASK)) begin
            mask_d = wr_data_s;
        end else begin
            mask_d = mask_q;
        end
        if (wr_en_s && (dp_addr_q == REG_STAT)) begin
            status_d = status_q & ~wr_data_s;
        end else begin
            status_d = status_q;
        end
        status_d = status_d | (sync_in_s[DATA_W-1:0] & ~edge_q & ~dir_q);
    end

    // Interrupt registers: mask, status, edge history and the IRQ output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            status_q <= '0;
            edge_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            status_q <= status_d;
            edge_q   <= sync_in_s[DATA_W-1:0];
            irq_q    <= |(status_q & mask_q);
        end
    end

    assign GPIOIRQ = irq_q;
`else
    assign GPIOIRQ = 1'b0;
`endif

    // Read mux: live only in a read data phase, unmapped offsets read zero.
    always_comb begin
        rdata_s = 32'd0;
        if (dp_valid_q && !dp_write_q) begin
            case (dp_addr_q)
                REG_DATA: rdata_s = zext_f((out_q & dir_q) | (sync_in_s[DATA_W-1:0] & ~dir_q));
                REG_DIR:  rdata_s = zext_f(dir_q);
`ifdef GPIO_IRQ_EN
                REG_MASK: rdata_s = zext_f(mask_q);
                REG_STAT: rdata_s = zext_f(status_q);
`endif
                REG_PERR: rdata_s = {31'd0, perr_sticky_q};
                default:  rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign HRDATA = rdata_s;

endmodule
